// File: rtl/ring_vc_arbiter.sv
// ring_vc_arbiter
//   Arbitrates NUM_VC virtual channels of a ring router. Each cycle exactly
//   one VC (vc_phase) is served. The three input buffer heads (cw, ccw, pe)
//   of that VC are decoded into one output request each. The CW, CCW and PE
//   output buffers are then arbitrated round-robin, with separate state kept
//   per VC. Grants, pops and writes are combinational; the phase and the
//   round-robin state are registered.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   en                         global enable (0: no grants, state holds)
//   *_in_data   [NUM_VC*DATA_W] input buffer heads, VC v at [v*DATA_W +: DATA_W]
//   *_in_valid  [NUM_VC]        head valid per VC
//   *_out_empty [NUM_VC]        output buffer empty per VC
//   *_in_clear  [NUM_VC]        pop strobe for the head of the input VC
//   *_out_data  [DATA_W]        write data for the active VC
//   *_out_enable[NUM_VC]        one-hot write strobe to the output VC
//   vc_phase    [VW]            VC served this cycle
module ring_vc_arbiter #(
    parameter  int DATA_W  = 64,
    parameter  int NUM_VC  = 2,
    parameter  int DIR_BIT = 62,
    parameter  int HOP_HI  = 55,
    parameter  int HOP_LO  = 48,
    localparam int HW      = HOP_HI - HOP_LO + 1,
    localparam int VW      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_VC*DATA_W-1:0] cw_in_data,
    input  logic [NUM_VC*DATA_W-1:0] ccw_in_data,
    input  logic [NUM_VC*DATA_W-1:0] pe_in_data,
    input  logic [NUM_VC-1:0]        cw_in_valid,
    input  logic [NUM_VC-1:0]        ccw_in_valid,
    input  logic [NUM_VC-1:0]        pe_in_valid,
    input  logic [NUM_VC-1:0]        cw_out_empty,
    input  logic [NUM_VC-1:0]        ccw_out_empty,
    input  logic [NUM_VC-1:0]        pe_out_empty,
    output logic [NUM_VC-1:0]        cw_in_clear,
    output logic [NUM_VC-1:0]        ccw_in_clear,
    output logic [NUM_VC-1:0]        pe_in_clear,
    output logic [DATA_W-1:0]        cw_out_data,
    output logic [DATA_W-1:0]        ccw_out_data,
    output logic [DATA_W-1:0]        pe_out_data,
    output logic [NUM_VC-1:0]        cw_out_enable,
    output logic [NUM_VC-1:0]        ccw_out_enable,
    output logic [NUM_VC-1:0]        pe_out_enable,
    output logic [VW-1:0]            vc_phase
);

    // Registered state
    logic [VW-1:0]           phase_q, phase_d;
    logic [NUM_VC-1:0]       cw_pri_q, cw_pri_d;    // 1: pe_in favoured on CW
    logic [NUM_VC-1:0]       ccw_pri_q, ccw_pri_d;  // 1: pe_in favoured on CCW
    logic [NUM_VC-1:0][1:0]  pe_ptr_q, pe_ptr_d;    // PE output pointer (0..2)

    // Active VC view
    logic [DATA_W-1:0] cw_h, ccw_h, pe_h;
    logic              cw_v, ccw_v, pe_v;
    logic              cw_e, ccw_e, pe_e;
    logic              go;

    // Requests: <source>_<target>
    logic req_cw_cw, req_cw_pe, req_ccw_ccw, req_ccw_pe;
    logic req_pe_cw, req_pe_ccw, req_pe_pe;

    // Grants
    logic       g_cw_cw, g_cw_pe;     // CW output: from cw_in / pe_in
    logic       g_ccw_ccw, g_ccw_pe;  // CCW output: from ccw_in / pe_in
    logic [2:0] g_pe;                 // PE output: one-hot over cw, ccw, pe
    logic [1:0] pe_win;               // 3 = no winner
    logic [NUM_VC-1:0] vc_onehot;

    function automatic logic [DATA_W-1:0] dec_hop(input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] r;
        r = p;
        if (p[HOP_HI:HOP_LO] != '0)
            r[HOP_HI:HOP_LO] = p[HOP_HI:HOP_LO] - HW'(1);
        return r;
    endfunction

    // Select the active VC and decode requests
    always_comb begin
        cw_h  = cw_in_data[int'(phase_q)*DATA_W +: DATA_W];
        ccw_h = ccw_in_data[int'(phase_q)*DATA_W +: DATA_W];
        pe_h  = pe_in_data[int'(phase_q)*DATA_W +: DATA_W];
        cw_v  = cw_in_valid[phase_q];
        ccw_v = ccw_in_valid[phase_q];
        pe_v  = pe_in_valid[phase_q];
        cw_e  = cw_out_empty[phase_q];
        ccw_e = ccw_out_empty[phase_q];
        pe_e  = pe_out_empty[phase_q];
        go    = en & ~reset;

        req_cw_pe   = go & cw_v  & (cw_h[HOP_HI:HOP_LO] == '0) & pe_e;
        req_cw_cw   = go & cw_v  & (cw_h[HOP_HI:HOP_LO] != '0) & cw_e;
        req_ccw_pe  = go & ccw_v & (ccw_h[HOP_HI:HOP_LO] == '0) & pe_e;
        req_ccw_ccw = go & ccw_v & (ccw_h[HOP_HI:HOP_LO] != '0) & ccw_e;
        req_pe_pe   = go & pe_v  & (pe_h[HOP_HI:HOP_LO] == '0) & pe_e;
        req_pe_cw   = go & pe_v  & (pe_h[HOP_HI:HOP_LO] != '0) & ~pe_h[DIR_BIT] & cw_e;
        req_pe_ccw  = go & pe_v  & (pe_h[HOP_HI:HOP_LO] != '0) &  pe_h[DIR_BIT] & ccw_e;
    end

    // Arbitration for the active VC
    always_comb begin
        logic [2:0] r;
        int         idx;

        g_cw_cw   = req_cw_cw & (~cw_pri_q[phase_q] | ~req_pe_cw);
        g_cw_pe   = req_pe_cw & ~g_cw_cw;
        g_ccw_ccw = req_ccw_ccw & (~ccw_pri_q[phase_q] | ~req_pe_ccw);
        g_ccw_pe  = req_pe_ccw & ~g_ccw_ccw;

        // Search starts at the pointer and wraps through the other two.
        r      = {req_pe_pe, req_ccw_pe, req_cw_pe};
        pe_win = 2'd3;
        for (int k = 0; k < 3; k++) begin
            idx = (int'(pe_ptr_q[phase_q]) + k) % 3;
            if (pe_win == 2'd3 && r[idx]) pe_win = 2'(idx);
        end
        g_pe = '0;
        if (pe_win != 2'd3) g_pe[pe_win] = 1'b1;
    end

    // Next state; grants are already gated by en and reset
    always_comb begin
        phase_d   = phase_q;
        cw_pri_d  = cw_pri_q;
        ccw_pri_d = ccw_pri_q;
        pe_ptr_d  = pe_ptr_q;

        if (en) phase_d = (phase_q == VW'(NUM_VC - 1)) ? '0 : phase_q + VW'(1);

        // The side that did not win gets priority next time.
        if (g_cw_cw | g_cw_pe)     cw_pri_d[phase_q]  = g_cw_cw;
        if (g_ccw_ccw | g_ccw_pe)  ccw_pri_d[phase_q] = g_ccw_ccw;
        if (pe_win != 2'd3)        pe_ptr_d[phase_q]  = (pe_win == 2'd2) ? 2'd0 : pe_win + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= '0;
            cw_pri_q  <= '0;
            ccw_pri_q <= '0;
            pe_ptr_q  <= '0;
        end else begin
            phase_q   <= phase_d;
            cw_pri_q  <= cw_pri_d;
            ccw_pri_q <= ccw_pri_d;
            pe_ptr_q  <= pe_ptr_d;
        end
    end

    // Output strobes and data
    always_comb begin
        vc_onehot      = NUM_VC'(1) << phase_q;

        cw_out_enable  = (g_cw_cw | g_cw_pe)     ? vc_onehot : '0;
        ccw_out_enable = (g_ccw_ccw | g_ccw_pe)  ? vc_onehot : '0;
        pe_out_enable  = (|g_pe)                 ? vc_onehot : '0;

        cw_in_clear    = (g_cw_cw | g_pe[0])             ? vc_onehot : '0;
        ccw_in_clear   = (g_ccw_ccw | g_pe[1])           ? vc_onehot : '0;
        pe_in_clear    = (g_cw_pe | g_ccw_pe | g_pe[2])  ? vc_onehot : '0;

        cw_out_data    = '0;
        if (g_cw_cw)        cw_out_data = dec_hop(cw_h);
        else if (g_cw_pe)   cw_out_data = dec_hop(pe_h);

        ccw_out_data   = '0;
        if (g_ccw_ccw)      ccw_out_data = dec_hop(ccw_h);
        else if (g_ccw_pe)  ccw_out_data = dec_hop(pe_h);

        // PE writes deliver the packet unmodified.
        pe_out_data    = '0;
        if (g_pe[0])        pe_out_data = cw_h;
        else if (g_pe[1])   pe_out_data = ccw_h;
        else if (g_pe[2])   pe_out_data = pe_h;

        vc_phase       = phase_q;
    end

endmodule
